// File: rtl/ace_snoop_responder.sv
// ace_snoop_responder
// Master-side ACE snoop responder for the data cache. One snoop at a time:
// the AC request is latched, the line is looked up (with a coherence action)
// through the cache snoop port, then CRRESP is returned and, when data is
// transferred, the whole line is streamed out as CD beats in ascending order.
//
// Ports
//   clk_i, rst_ni            clock, synchronous active-low reset
//   ac_valid_i/ac_ready_o    snoop request handshake
//   ac_addr_i, ac_snoop_i    snoop address and ACSNOOP; ac_prot_i is ignored
//   cr_valid_o/cr_ready_i    snoop response handshake, cr_resp_o = CRRESP
//   cd_valid_o/cd_ready_i    snoop data handshake, cd_data_o beat, cd_last_o
//   lkp_req_o/lkp_gnt_i      cache lookup request handshake
//   lkp_addr_o, lkp_op_o     line-aligned address and post-read action
//   lkp_rvalid_i             one-cycle lookup result strobe with
//                            lkp_hit_i/lkp_dirty_i/lkp_shared_i/lkp_data_i
module ace_snoop_responder #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned LINE_WIDTH = 128,
  parameter int unsigned ADDR_WIDTH = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  ac_valid_i,
  output logic                  ac_ready_o,
  input  logic [ADDR_WIDTH-1:0] ac_addr_i,
  input  logic [3:0]            ac_snoop_i,
  input  logic [2:0]            ac_prot_i,
  output logic                  cr_valid_o,
  input  logic                  cr_ready_i,
  output logic [4:0]            cr_resp_o,
  output logic                  cd_valid_o,
  input  logic                  cd_ready_i,
  output logic [DATA_WIDTH-1:0] cd_data_o,
  output logic                  cd_last_o,
  output logic                  lkp_req_o,
  input  logic                  lkp_gnt_i,
  output logic [ADDR_WIDTH-1:0] lkp_addr_o,
  output logic [1:0]            lkp_op_o,
  input  logic                  lkp_rvalid_i,
  input  logic                  lkp_hit_i,
  input  logic                  lkp_dirty_i,
  input  logic                  lkp_shared_i,
  input  logic [LINE_WIDTH-1:0] lkp_data_i
);

  localparam int unsigned BEATS = LINE_WIDTH / DATA_WIDTH;
  localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned OFFS  = $clog2(LINE_WIDTH / 8);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, LOOKUP, WAIT, RESP} state_e;

  state_e                state_q, state_d;
  logic [3:0]            snoop_q, snoop_d;
  logic                  lkp_req_q, lkp_req_d;
  logic [ADDR_WIDTH-1:0] lkp_addr_q, lkp_addr_d;
  logic [1:0]            lkp_op_q, lkp_op_d;
  logic [LINE_WIDTH-1:0] line_q, line_d;
  logic [BW-1:0]         beat_q, beat_d;
  logic                  cr_valid_q, cr_valid_d;
  logic [4:0]            cr_resp_q, cr_resp_d;
  logic                  cd_valid_q, cd_valid_d;
  logic [DATA_WIDTH-1:0] cd_data_q, cd_data_d;
  logic                  cd_last_q, cd_last_d;

  logic [DATA_WIDTH-1:0] line_beats [BEATS];
  logic [BW-1:0]         beat_nxt;
  logic [2:0]            dec;
  logic [4:0]            resp;
  logic                  unused_inputs;

  // Low address bits and protection are irrelevant to a line-granular snoop.
  assign unused_inputs = ^{ac_prot_i, ac_addr_i[OFFS-1:0]};

  for (genvar gi = 0; gi < BEATS; gi++) begin : g_beats
    assign line_beats[gi] = line_q[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  // {supported, op}: op 00 none, 01 mark clean, 10 invalidate if hit.
  function automatic logic [2:0] decode(input logic [3:0] s);
    case (s)
      4'b0000, 4'b0010:          decode = 3'b1_00;
      4'b0001, 4'b0011, 4'b1000: decode = 3'b1_01;
      4'b0111, 4'b1001, 4'b1101: decode = 3'b1_10;
      default:                   decode = 3'b0_00;
    endcase
  endfunction

  // CRRESP = {WasUnique, IsShared, PassDirty, Error, DataTransfer}.
  function automatic logic [4:0] resp_calc(input logic [3:0] s, input logic hit,
                                           input logic dirty, input logic shared);
    logic dt, pd, sh;
    dt = 1'b0;
    pd = 1'b0;
    sh = 1'b0;
    case (s)
      4'b0000, 4'b0010: begin dt = 1'b1;  sh = 1'b1; end
      4'b0001, 4'b0011: begin dt = 1'b1;  sh = 1'b1; pd = dirty; end
      4'b0111:          begin dt = 1'b1;  pd = dirty; end
      4'b1000:          begin dt = dirty; pd = dirty; sh = 1'b1; end
      4'b1001:          begin dt = dirty; pd = dirty; end
      default:          ;
    endcase
    resp_calc = hit ? {~shared, sh, pd, 1'b0, dt} : 5'b0;
  endfunction

  assign dec        = decode(ac_snoop_i);
  assign resp       = resp_calc(snoop_q, lkp_hit_i, lkp_dirty_i, lkp_shared_i);
  assign beat_nxt   = beat_q + 1'b1;
  assign ac_ready_o = rst_ni && (state_q == IDLE);

  always_comb begin
    state_d    = state_q;
    snoop_d    = snoop_q;
    lkp_req_d  = lkp_req_q;
    lkp_addr_d = lkp_addr_q;
    lkp_op_d   = lkp_op_q;
    line_d     = line_q;
    beat_d     = beat_q;
    cr_valid_d = cr_valid_q;
    cr_resp_d  = cr_resp_q;
    cd_valid_d = cd_valid_q;
    cd_data_d  = cd_data_q;
    cd_last_d  = cd_last_q;
    case (state_q)
      IDLE: begin
        if (ac_valid_i) begin
          snoop_d = ac_snoop_i;
          beat_d  = '0;
          if (dec[2]) begin
            lkp_addr_d = {ac_addr_i[ADDR_WIDTH-1:OFFS], {OFFS{1'b0}}};
            lkp_op_d   = dec[1:0];
            lkp_req_d  = 1'b1;
            state_d    = LOOKUP;
          end else begin
            // DVM and unknown encodings are answered without touching the cache.
            cr_valid_d = 1'b1;
            cr_resp_d  = 5'b0;
            cd_valid_d = 1'b0;
            cd_last_d  = 1'b0;
            state_d    = RESP;
          end
        end
      end
      LOOKUP: begin
        if (lkp_gnt_i) begin
          lkp_req_d = 1'b0;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (lkp_rvalid_i) begin
          line_d     = lkp_data_i;
          beat_d     = '0;
          cr_valid_d = 1'b1;
          cr_resp_d  = resp;
          cd_valid_d = resp[0];
          cd_data_d  = lkp_data_i[DATA_WIDTH-1:0];
          cd_last_d  = resp[0] && (BEATS == 1);
          state_d    = RESP;
        end
      end
      RESP: begin
        if (cr_valid_q && cr_ready_i) cr_valid_d = 1'b0;
        if (cd_valid_q && cd_ready_i) begin
          if (beat_q == LAST_BEAT) begin
            cd_valid_d = 1'b0;
            cd_last_d  = 1'b0;
          end else begin
            beat_d    = beat_nxt;
            cd_data_d = line_beats[beat_nxt];
            cd_last_d = (beat_nxt == LAST_BEAT);
          end
        end
        // CR and CD retire independently; leave once both are finished.
        if (!cr_valid_d && !cd_valid_d) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      snoop_q    <= '0;
      lkp_req_q  <= 1'b0;
      lkp_addr_q <= '0;
      lkp_op_q   <= '0;
      line_q     <= '0;
      beat_q     <= '0;
      cr_valid_q <= 1'b0;
      cr_resp_q  <= '0;
      cd_valid_q <= 1'b0;
      cd_data_q  <= '0;
      cd_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      snoop_q    <= snoop_d;
      lkp_req_q  <= lkp_req_d;
      lkp_addr_q <= lkp_addr_d;
      lkp_op_q   <= lkp_op_d;
      line_q     <= line_d;
      beat_q     <= beat_d;
      cr_valid_q <= cr_valid_d;
      cr_resp_q  <= cr_resp_d;
      cd_valid_q <= cd_valid_d;
      cd_data_q  <= cd_data_d;
      cd_last_q  <= cd_last_d;
    end
  end

  assign lkp_req_o  = lkp_req_q;
  assign lkp_addr_o = lkp_addr_q;
  assign lkp_op_o   = lkp_op_q;
  assign cr_valid_o = cr_valid_q;
  assign cr_resp_o  = cr_resp_q;
  assign cd_valid_o = cd_valid_q;
  assign cd_data_o  = cd_data_q;
  assign cd_last_o  = cd_last_q;

endmodule
